// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the I/D memory arbiter.
// The state enum, the grant encoding and the full-word byte-enable live here.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam logic       GRANT_I   = 1'b0;
  localparam logic       GRANT_D   = 1'b1;
  localparam logic [3:0] BE_WORD   = 4'hF;
  localparam int         STARVE_CW = 4;

endpackage

// File: rtl/riscv_arb_starve_ctr.sv
// Saturating count of consecutive D grants made while a fetch was waiting.
// Clear wins over increment; at_limit flags that the fetch port must win next.
module riscv_arb_starve_ctr
  import riscv_mem_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 clr,
  output logic [STARVE_CW-1:0] cnt,
  output logic                 at_limit
);

  localparam logic [STARVE_CW-1:0] MAX_C = STARVE_CW'(STARVE_MAX);

  logic [STARVE_CW-1:0] cnt_q;
  logic [STARVE_CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q < MAX_C)) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt      = cnt_q;
  assign at_limit = (cnt_q >= MAX_C);

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares one single-port memory between the fetch (I) and data (D) ports.
// D has priority unless the fetch port has been passed over STARVE_MAX times in a row.
module riscv_mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  arb_state_e          state_q,   state_d;
  logic                grant_q,   grant_d;
  logic [ADDR_W-1:0]   addr_q,    addr_d;
  logic                we_q,      we_d;
  logic [3:0]          be_q,      be_d;
  logic [DATA_W-1:0]   wdata_q,   wdata_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

  logic                 starve_inc_s;
  logic                 starve_clr_s;
  logic                 starve_limit_s;
  logic [STARVE_CW-1:0] starve_cnt_s;
  logic                 pick_d_s;

  riscv_arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk     (clk),
    .rst     (rst),
    .inc     (starve_inc_s),
    .clr     (starve_clr_s),
    .cnt     (starve_cnt_s),
    .at_limit(starve_limit_s)
  );

  // D wins unless a fetch is waiting and has already been passed over STARVE_MAX times.
  assign pick_d_s = d_req && (!i_req || (starve_cnt_s < STARVE_CW'(STARVE_MAX)));

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
    we_d         = we_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    starve_inc_s = 1'b0;
    starve_clr_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          state_d = BUS;
          if (pick_d_s) begin
            grant_d      = GRANT_D;
            addr_d       = d_addr;
            we_d         = d_we;
            be_d         = d_be;
            wdata_d      = d_wdata;
            starve_inc_s = i_req && !starve_limit_s;
          end else begin
            grant_d      = GRANT_I;
            addr_d       = i_addr;
            we_d         = 1'b0;
            be_d         = BE_WORD;
            wdata_d      = '0;
            starve_clr_s = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUS: begin
        if (mem_ack) begin
          state_d = RESP;
          // Stores report zero read data rather than whatever the memory returns.
          if (grant_q == GRANT_D) begin
            d_rdata_d = we_q ? '0 : mem_rdata;
          end else begin
            i_rdata_d = mem_rdata;
          end
        end else begin
          state_d = BUS;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= GRANT_I;
      addr_q    <= '0;
      we_q      <= 1'b0;
      be_q      <= 4'h0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign mem_req   = (state_q == BUS);
  assign mem_we    = we_q;
  assign mem_be    = be_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_ready   = (state_q == RESP) && (grant_q == GRANT_I);
  assign d_ready   = (state_q == RESP) && (grant_q == GRANT_D);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter: fetch, store, contention, latch stability,
// reset mid-transaction and back-to-back requests.
module tb_riscv_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  int i_pulses = 0;
  int d_pulses = 0;

  riscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (i_ready) i_pulses <= i_pulses + 1;
    if (d_ready) d_pulses <= d_pulses + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int          base_d;
  int          base_all;
  logic        grant_is_d;
  logic [5:0]  exp_order;

  initial begin
    rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
    d_addr = '0; d_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    check_eq("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check_eq("rst_busy",    {31'd0, busy},    32'd0);
    check_eq("rst_ready",   {30'd0, i_ready, d_ready}, 32'd0);
    check_eq("rst_rdata",   i_rdata | d_rdata | mem_addr, 32'd0);

    // Lone fetch, ack on the second BUS cycle.
    i_req = 1'b1; i_addr = 32'h40;
    tick();
    check_eq("fetch_mem_req",  {31'd0, mem_req}, 32'd1);
    check_eq("fetch_mem_addr", mem_addr, 32'h40);
    check_eq("fetch_mem_we",   {31'd0, mem_we}, 32'd0);
    check_eq("fetch_mem_be",   {28'd0, mem_be}, 32'hF);
    check_eq("fetch_wdata",    mem_wdata, 32'd0);
    tick();
    check_eq("fetch_no_early_ready", {31'd0, i_ready}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
    tick();
    mem_ack = 1'b0; i_req = 1'b0;
    check_eq("fetch_i_ready", {31'd0, i_ready}, 32'd1);
    check_eq("fetch_i_rdata", i_rdata, 32'h0050_0093);
    check_eq("fetch_d_ready", {31'd0, d_ready}, 32'd0);
    check_eq("fetch_resp_mem_req", {31'd0, mem_req}, 32'd0);
    tick();
    check_eq("fetch_idle_ready", {31'd0, i_ready}, 32'd0);
    check_eq("fetch_idle_busy",  {31'd0, busy}, 32'd0);

    // Store, with the live address changed mid-BUS, then a back-to-back load.
    base_d = d_pulses;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h100; d_wdata = 32'hBEEF;
    tick();
    check_eq("store_mem_we",    {31'd0, mem_we}, 32'd1);
    check_eq("store_mem_be",    {28'd0, mem_be}, 32'h3);
    check_eq("store_mem_addr",  mem_addr, 32'h100);
    check_eq("store_mem_wdata", mem_wdata, 32'hBEEF);
    d_addr = 32'h200; d_wdata = 32'h1111; d_be = 4'hF;
    tick();
    check_eq("latch_mem_addr", mem_addr, 32'h100);
    check_eq("latch_mem_be",   {28'd0, mem_be}, 32'h3);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0;
    check_eq("store_d_ready", {31'd0, d_ready}, 32'd1);
    check_eq("store_d_rdata", d_rdata, 32'd0);
    d_addr = 32'h104; d_we = 1'b0; d_be = 4'hF;
    tick();
    check_eq("b2b_idle_busy", {31'd0, busy}, 32'd0);
    check_eq("b2b_idle_ready", {31'd0, d_ready}, 32'd0);
    tick();
    check_eq("b2b_mem_addr", mem_addr, 32'h104);
    check_eq("b2b_mem_we",   {31'd0, mem_we}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 1'b0; d_req = 1'b0;
    check_eq("b2b_d_rdata", d_rdata, 32'h1234_5678);
    tick(); tick(); tick();
    check_eq("b2b_pulses", d_pulses - base_d, 32'd2);

    // Contention: both ports held, D wins until the fetch has waited 4 grants.
    exp_order = 6'b101111;
    i_req = 1'b1; i_addr = 32'h40; d_req = 1'b1; d_addr = 32'h300; d_we = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      grant_is_d = (mem_addr == 32'h300);
      check_eq($sformatf("grant_%0d", k), {31'd0, grant_is_d}, {31'd0, exp_order[k]});
      if (k == 4) check_eq("starve_clr", {28'd0, dut.starve_cnt_s}, 32'd0);
      if (k == 3) check_eq("starve_sat", {28'd0, dut.starve_cnt_s}, 32'd4);
      mem_ack = 1'b1; mem_rdata = 32'h0000_0A00 + 32'(k);
      tick();
      mem_ack = 1'b0;
      check_eq($sformatf("one_ready_%0d", k), {30'd0, i_ready, d_ready},
               exp_order[k] ? 32'd1 : 32'd2);
      tick();
    end
    check_eq("starve_after_d", {28'd0, dut.starve_cnt_s}, 32'd1);

    // Reset while in BUS, then a stray ack two cycles later.
    tick();
    check_eq("pre_rst_busy", {31'd0, busy}, 32'd1);
    base_all = i_pulses + d_pulses;
    rst = 1'b1;
    tick();
    rst = 1'b0; i_req = 1'b0; d_req = 1'b0;
    check_eq("rst_mid_mem_req", {31'd0, mem_req}, 32'd0);
    check_eq("rst_mid_busy",    {31'd0, busy}, 32'd0);
    check_eq("rst_mid_cnt",     {28'd0, dut.starve_cnt_s}, 32'd0);
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_ack = 1'b0;
    check_eq("stray_ack_busy", {31'd0, busy}, 32'd0);
    tick();
    check_eq("stray_ack_pulses", (i_pulses + d_pulses) - base_all, 32'd0);
    check_eq("stray_ack_rdata", d_rdata | i_rdata, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
